// File: rtl/frame_store_writer.sv
// frame_store_writer
// Write-side feeder of the external frame-store RAM. Reconstructed 4x4
// blocks (Y, U or V) are accepted, given their planar YUV 4:2:0 byte address
// inside the current picture slot, buffered, and written out as four 32-bit
// row writes per block.
//
// Ports:
//   clk, rst                        single clock, synchronous active-high reset
//   start_of_frame, pic_num,        latch picture geometry and slot index
//   pic_width_in_mbs_minus1,
//   pic_height_in_map_units_minus1
//   blk_valid / blk_ready           block handshake
//   blk_comp, mb_x, mb_y,           block component and position
//   blk_x, blk_y
//   blk_data                        16 pixels, row-major, pixel(r,c) at byte r*4+c
//   ext_wr, ext_wr_addr,            RAM write port (one row per write)
//   ext_wr_data
//   write_to_ram_idle               nothing buffered and nothing being written
//   err                             sticky bounds error
//
// Build option: define FRAME_STORE_BOUNDS_CHECK_EN to drop out-of-range
// blocks and raise err; otherwise err is tied low.

module frame_store_writer #(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int ADDR_W          = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_of_frame,
  input  logic [2:0]        pic_num,
  input  logic [7:0]        pic_width_in_mbs_minus1,
  input  logic [7:0]        pic_height_in_map_units_minus1,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [1:0]        blk_comp,
  input  logic [7:0]        mb_x,
  input  logic [7:0]        mb_y,
  input  logic [1:0]        blk_x,
  input  logic [1:0]        blk_y,
  input  logic [127:0]      blk_data,
  output logic              ext_wr,
  output logic [ADDR_W-1:0] ext_wr_addr,
  output logic [31:0]       ext_wr_data,
  output logic              write_to_ram_idle,
  output logic              err
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1);
  localparam logic [CW-1:0]              CNT_ONE   = CW'(1);
  localparam logic [CW:0]                OCC_LIMIT = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0]          A_ONE     = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW0,
    S_ROW1,
    S_ROW2,
    S_ROW3
  } wr_state_t;

  // ---------------------------------------------------------------------
  // Geometry
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] new_w, new_h, new_wh, new_fbase, new_ubase, new_vbase;
  logic [ADDR_W-1:0] geo_w, geo_fbase, geo_ubase, geo_vbase;

  // Frame size is W*H*3/2; W*H is a multiple of 256, so the halving is exact.
  always_comb begin
    new_w     = (ADDR_W'(pic_width_in_mbs_minus1) + A_ONE) << 4;
    new_h     = (ADDR_W'(pic_height_in_map_units_minus1) + A_ONE) << 4;
    new_wh    = new_w * new_h;
    new_fbase = (new_wh + (new_wh >> 1)) * ADDR_W'(pic_num);
    new_ubase = new_fbase + new_wh;
    new_vbase = new_ubase + (new_wh >> 2);
  end

  // Geometry is captured on the start_of_frame pulse and holds until the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      geo_w     <= '0;
      geo_fbase <= '0;
      geo_ubase <= '0;
      geo_vbase <= '0;
    end else if (start_of_frame) begin
      geo_w     <= new_w;
      geo_fbase <= new_fbase;
      geo_ubase <= new_ubase;
      geo_vbase <= new_vbase;
    end
  end

  // ---------------------------------------------------------------------
  // Accept and address stage
  // ---------------------------------------------------------------------
  logic              accept;
  logic              stg_valid;
  logic [1:0]        stg_comp;
  logic [7:0]        stg_mb_x, stg_mb_y;
  logic [1:0]        stg_blk_x, stg_blk_y;
  logic [127:0]      stg_data;
  logic [ADDR_W-1:0] stg_base, stg_row, stg_col, stg_pitch, stg_addr;
  logic              stg_keep;

  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occ;

  // The address-stage slot counts toward occupancy so a block sitting in
  // the stage always has a FIFO slot (or the write FSM) to move into.
  assign occ       = {1'b0, fifo_count} + {{CW{1'b0}}, stg_valid};
  assign blk_ready = (occ < OCC_LIMIT);
  assign accept    = blk_valid && blk_ready;

  // The stage holds the raw block for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= 1'b0;
    end else begin
      stg_valid <= accept;
    end
    if (accept) begin
      stg_comp  <= blk_comp;
      stg_mb_x  <= mb_x;
      stg_mb_y  <= mb_y;
      stg_blk_x <= blk_x;
      stg_blk_y <= blk_y;
      stg_data  <= blk_data;
    end
  end

  // Luma uses 16-pixel MBs at pitch W; chroma uses 8-pixel MBs at pitch W/2.
  always_comb begin
    stg_base  = geo_fbase;
    stg_pitch = geo_w;
    stg_row   = (ADDR_W'(stg_mb_y) << 4) + (ADDR_W'(stg_blk_y) << 2);
    stg_col   = (ADDR_W'(stg_mb_x) << 4) + (ADDR_W'(stg_blk_x) << 2);
    if (stg_comp != 2'd0) begin
      stg_base  = (stg_comp == 2'd1) ? geo_ubase : geo_vbase;
      stg_pitch = geo_w >> 1;
      stg_row   = (ADDR_W'(stg_mb_y) << 3) + (ADDR_W'(stg_blk_y) << 2);
      stg_col   = (ADDR_W'(stg_mb_x) << 3) + (ADDR_W'(stg_blk_x) << 2);
    end
    stg_addr = stg_base + stg_row * stg_pitch + stg_col;
  end

`ifdef FRAME_STORE_BOUNDS_CHECK_EN
  logic [7:0] geo_pwm1, geo_phm1;
  logic       stg_flag;
  logic       err_q;

  // MB limits used by the bounds check, captured with the rest of the geometry.
  always_ff @(posedge clk) begin
    if (rst) begin
      geo_pwm1 <= '0;
      geo_phm1 <= '0;
    end else if (start_of_frame) begin
      geo_pwm1 <= pic_width_in_mbs_minus1;
      geo_phm1 <= pic_height_in_map_units_minus1;
    end
  end

  assign stg_flag = (stg_mb_x > geo_pwm1) || (stg_mb_y > geo_phm1) ||
                    (stg_comp == 2'd3) ||
                    ((stg_comp != 2'd0) && ((stg_blk_x > 2'd1) || (stg_blk_y > 2'd1)));
  assign stg_keep = stg_valid && !stg_flag;

  // err is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (stg_valid && stg_flag) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign stg_keep = stg_valid && (stg_comp != 2'd3);
  assign err      = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Block FIFO
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0]          fifo_addr  [DEPTH];
  logic [ADDR_W-1:0]          fifo_pitch [DEPTH];
  logic [127:0]               fifo_data  [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                       fifo_empty;
  logic                       push, pop, take;

  wr_state_t                  state;
  logic [ADDR_W-1:0]          next_addr, next_pitch;
  logic [127:0]               next_data;

  assign fifo_empty = (fifo_count == '0);

  // The FSM takes a new block in IDLE or ROW3. FIFO entries are older than
  // the stage, so the stage bypasses straight to the FSM only when the FIFO
  // is empty; that bypass is what gives the two-cycle accept-to-write latency.
  assign take = ((state == S_IDLE) || (state == S_ROW3)) && (!fifo_empty || stg_keep);
  assign pop  = take && !fifo_empty;
  assign push = stg_keep && !(take && fifo_empty);

  always_comb begin
    next_addr  = stg_addr;
    next_pitch = stg_pitch;
    next_data  = stg_data;
    if (!fifo_empty) begin
      next_addr  = fifo_addr[rd_ptr];
      next_pitch = fifo_pitch[rd_ptr];
      next_data  = fifo_data[rd_ptr];
    end
  end

  // FIFO storage needs no reset; only the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= stg_addr;
      fifo_pitch[wr_ptr] <= stg_pitch;
      fifo_data[wr_ptr]  <= stg_data;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop may coincide at any level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_ONE;
      end else if (!push && pop) begin
        fifo_count <= fifo_count - CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Row-write FSM
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] cur_pitch;
  logic [127:0]      cur_data;

  // Each ROWn state is the cycle in which row n is on the write port. The
  // address advances by the component pitch; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ext_wr      <= 1'b0;
      ext_wr_addr <= '0;
      ext_wr_data <= '0;
      cur_pitch   <= '0;
      cur_data    <= '0;
    end else begin
      case (state)
        S_IDLE, S_ROW3: begin
          if (take) begin
            state       <= S_ROW0;
            ext_wr      <= 1'b1;
            ext_wr_addr <= next_addr;
            ext_wr_data <= next_data[31:0];
            cur_pitch   <= next_pitch;
            cur_data    <= next_data;
          end else begin
            state  <= S_IDLE;
            ext_wr <= 1'b0;
          end
        end
        S_ROW0: begin
          state       <= S_ROW1;
          ext_wr_addr <= ext_wr_addr + cur_pitch;
          ext_wr_data <= cur_data[63:32];
        end
        S_ROW1: begin
          state       <= S_ROW2;
          ext_wr_addr <= ext_wr_addr + cur_pitch;
          ext_wr_data <= cur_data[95:64];
        end
        S_ROW2: begin
          state       <= S_ROW3;
          ext_wr_addr <= ext_wr_addr + cur_pitch;
          ext_wr_data <= cur_data[127:96];
        end
        default: begin
          state  <= S_IDLE;
          ext_wr <= 1'b0;
        end
      endcase
    end
  end

  assign write_to_ram_idle = fifo_empty && !stg_valid && (state == S_IDLE);

endmodule

// File: tb/tb_frame_store_writer.sv
// tb_frame_store_writer
// Directed bench for frame_store_writer. A monitor logs every RAM write
// (cycle, address, data); each scenario then compares the log against
// hand-computed QCIF addresses and data.

module tb_frame_store_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_of_frame;
  logic [2:0]   pic_num;
  logic [7:0]   pwm1, phm1;
  logic         blk_valid;
  logic         blk_ready;
  logic [1:0]   blk_comp;
  logic [7:0]   mb_x, mb_y;
  logic [1:0]   blk_x, blk_y;
  logic [127:0] blk_data;
  logic         ext_wr;
  logic [25:0]  ext_wr_addr;
  logic [31:0]  ext_wr_data;
  logic         write_to_ram_idle;
  logic         err;

  int vectors     = 0;
  int miscompares = 0;

  int cyc = 0;
  int q_cyc[$];
  logic [25:0] q_addr[$];
  logic [31:0] q_data[$];
  int ready_drops = 0;
  logic prev_ready = 1'b1;
  logic prev_idle  = 1'b1;
  int idle_rise_cyc = -1;

  frame_store_writer dut (
    .clk                            (clk),
    .rst                            (rst),
    .start_of_frame                 (start_of_frame),
    .pic_num                        (pic_num),
    .pic_width_in_mbs_minus1        (pwm1),
    .pic_height_in_map_units_minus1 (phm1),
    .blk_valid                      (blk_valid),
    .blk_ready                      (blk_ready),
    .blk_comp                       (blk_comp),
    .mb_x                           (mb_x),
    .mb_y                           (mb_y),
    .blk_x                          (blk_x),
    .blk_y                          (blk_y),
    .blk_data                       (blk_data),
    .ext_wr                         (ext_wr),
    .ext_wr_addr                    (ext_wr_addr),
    .ext_wr_data                    (ext_wr_data),
    .write_to_ram_idle              (write_to_ram_idle),
    .err                            (err)
  );

  always #5 clk = ~clk;

  // Cycle counter; the value seen at a negedge names the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // Write log plus blk_ready falling edges and write_to_ram_idle rising edges.
  always @(negedge clk) begin
    if (ext_wr) begin
      q_cyc.push_back(cyc);
      q_addr.push_back(ext_wr_addr);
      q_data.push_back(ext_wr_data);
    end
    if (prev_ready && !blk_ready) ready_drops <= ready_drops + 1;
    if (!prev_idle && write_to_ram_idle) idle_rise_cyc <= cyc;
    prev_ready <= blk_ready;
    prev_idle  <= write_to_ram_idle;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mkData(input int k);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(k * 16 + i);
    return d;
  endfunction

  // Offers one block from a negedge and waits (bounded) for the handshake.
  // Returns at the following negedge with blk_valid still high so blocks
  // can be chained back-to-back.
  task automatic applyStimulus(input logic [1:0] comp, input logic [7:0] mx, input logic [7:0] my,
                               input logic [1:0] bx, input logic [1:0] by,
                               input logic [127:0] data, output int acc_cyc);
    int tries;
    blk_valid = 1'b1;
    blk_comp  = comp;
    mb_x      = mx;
    mb_y      = my;
    blk_x     = bx;
    blk_y     = by;
    blk_data  = data;
    acc_cyc   = -1;
    tries     = 0;
    while (!blk_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!blk_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
    else acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic startFrame(input logic [7:0] w, input logic [7:0] h, input logic [2:0] pn);
    pwm1 = w;
    phm1 = h;
    pic_num = pn;
    start_of_frame = 1'b1;
    @(negedge clk);
    start_of_frame = 1'b0;
    @(negedge clk);
  endtask

  // Compares four logged rows starting at log index idx.
  task automatic checkWrites(input string tag, input int idx, input logic [25:0] row0,
                             input logic [25:0] pitch, input logic [127:0] data);
    for (int r = 0; r < 4; r++) begin
      if (idx + r < q_addr.size()) begin
        checkOutput($sformatf("%s_addr%0d", tag, r), 64'(q_addr[idx+r]), 64'(row0 + 26'(r) * pitch));
        checkOutput($sformatf("%s_data%0d", tag, r), 64'(q_data[idx+r]), 64'(data[r*32 +: 32]));
      end else begin
        checkOutput($sformatf("%s_missing%0d", tag, r), 64'(q_addr.size()), 64'(idx + r + 1));
      end
    end
  endtask

  int base, acc, acc0, drops0;
  int gaps;
  logic [127:0] d1;

  initial begin
    rst = 1'b1;
    start_of_frame = 1'b0;
    pic_num = '0;
    pwm1 = '0;
    phm1 = '0;
    blk_valid = 1'b0;
    blk_comp = '0;
    mb_x = '0;
    mb_y = '0;
    blk_x = '0;
    blk_y = '0;
    blk_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_ext_wr", 64'(ext_wr), 64'd0);
    checkOutput("rst_addr", 64'(ext_wr_addr), 64'd0);
    checkOutput("rst_data", 64'(ext_wr_data), 64'd0);
    checkOutput("rst_ready", 64'(blk_ready), 64'd1);
    checkOutput("rst_idle", 64'(write_to_ram_idle), 64'd1);
    checkOutput("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: QCIF single Y block, latency and row data
    $display("[TB] test 1: single luma block");
    startFrame(8'd10, 8'd8, 3'd0);
    base = q_addr.size();
    d1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    applyStimulus(2'd0, 8'd0, 8'd0, 2'd0, 2'd0, d1, acc);
    blk_valid = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("t1_count", 64'(q_addr.size() - base), 64'd4);
    checkWrites("t1", base, 26'd0, 26'd176, d1);
    if (q_cyc.size() >= base + 4) begin
      checkOutput("t1_row0_cycle", 64'(q_cyc[base]), 64'(acc + 2));
      checkOutput("t1_row3_cycle", 64'(q_cyc[base+3]), 64'(acc + 5));
    end else begin
      checkOutput("t1_cycles_missing", 64'(q_cyc.size()), 64'(base + 4));
    end
    checkOutput("t1_hold_addr", 64'(ext_wr_addr), 64'd528);
    checkOutput("t1_hold_data", 64'(ext_wr_data), 64'h0F0E0D0C);
    checkOutput("t1_idle", 64'(write_to_ram_idle), 64'd1);

    // 2: chroma addressing, pic_num 1
    $display("[TB] test 2: chroma blocks");
    startFrame(8'd10, 8'd8, 3'd1);
    base = q_addr.size();
    applyStimulus(2'd1, 8'd1, 8'd2, 2'd1, 2'd0, mkData(2), acc);
    applyStimulus(2'd2, 8'd1, 8'd2, 2'd1, 2'd0, mkData(3), acc);
    blk_valid = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("t2_count", 64'(q_addr.size() - base), 64'd8);
    checkWrites("t2_u", base, 26'd64780, 26'd88, mkData(2));
    checkWrites("t2_v", base + 4, 26'd71116, 26'd88, mkData(3));

    // 3: five back-to-back blocks against a 4-deep FIFO
    $display("[TB] test 3: back-to-back burst");
    startFrame(8'd10, 8'd8, 3'd0);
    base = q_addr.size();
    drops0 = ready_drops;
    applyStimulus(2'd0, 8'd0, 8'd0, 2'd0, 2'd0, mkData(4), acc0);
    for (int k = 1; k < 5; k++)
      applyStimulus(2'd0, 8'(k), 8'd0, 2'd0, 2'd0, mkData(4 + k), acc);
    blk_valid = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("t3_count", 64'(q_addr.size() - base), 64'd20);
    checkOutput("t3_ready_drops", 64'(ready_drops - drops0), 64'd1);
    if (q_cyc.size() >= base + 20) begin
      gaps = 0;
      for (int i = 1; i < 20; i++)
        if (q_cyc[base+i] != q_cyc[base] + i) gaps++;
      checkOutput("t3_gaps", 64'(gaps), 64'd0);
      checkOutput("t3_first_cycle", 64'(q_cyc[base]), 64'(acc0 + 2));
      checkOutput("t3_idle_rise", 64'(idle_rise_cyc), 64'(q_cyc[base+19] + 1));
    end
    for (int k = 0; k < 5; k++)
      checkWrites($sformatf("t3_b%0d", k), base + 4 * k, 26'(k * 16), 26'd176, mkData(4 + k));

    // 4: new frame pulsed while pic 1 blocks are queued
    $display("[TB] test 4: start_of_frame with queued blocks");
    startFrame(8'd10, 8'd8, 3'd1);
    base = q_addr.size();
    applyStimulus(2'd0, 8'd0, 8'd0, 2'd0, 2'd0, mkData(9), acc);
    applyStimulus(2'd0, 8'd1, 8'd0, 2'd0, 2'd0, mkData(10), acc);
    applyStimulus(2'd0, 8'd2, 8'd0, 2'd0, 2'd0, mkData(11), acc);
    blk_valid = 1'b0;
    pic_num = 3'd2;
    start_of_frame = 1'b1;
    @(negedge clk);
    start_of_frame = 1'b0;
    @(negedge clk);
    applyStimulus(2'd0, 8'd0, 8'd0, 2'd0, 2'd0, mkData(12), acc);
    blk_valid = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t4_count", 64'(q_addr.size() - base), 64'd16);
    checkWrites("t4_a", base, 26'd38016, 26'd176, mkData(9));
    checkWrites("t4_b", base + 4, 26'd38032, 26'd176, mkData(10));
    checkWrites("t4_c", base + 8, 26'd38048, 26'd176, mkData(11));
    checkWrites("t4_d", base + 12, 26'd76032, 26'd176, mkData(12));

    // 5: reset after the second row write with another block queued
    $display("[TB] test 5: reset mid-block");
    startFrame(8'd10, 8'd8, 3'd0);
    base = q_addr.size();
    applyStimulus(2'd0, 8'd0, 8'd0, 2'd0, 2'd0, mkData(1), acc0);
    applyStimulus(2'd0, 8'd1, 8'd0, 2'd0, 2'd0, mkData(2), acc);
    blk_valid = 1'b0;
    for (int t = 0; t < 20 && cyc < acc0 + 3; t++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_ext_wr_after_rst", 64'(ext_wr), 64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("t5_count", 64'(q_addr.size() - base), 64'd2);
    checkOutput("t5_idle", 64'(write_to_ram_idle), 64'd1);
    checkOutput("t5_ready", 64'(blk_ready), 64'd1);

    // Illegal component is always dropped
    $display("[TB] test comp3: illegal component");
    startFrame(8'd10, 8'd8, 3'd0);
    base = q_addr.size();
    applyStimulus(2'd3, 8'd0, 8'd0, 2'd0, 2'd0, mkData(5), acc);
    blk_valid = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("c3_count", 64'(q_addr.size() - base), 64'd0);
    checkOutput("c3_idle", 64'(write_to_ram_idle), 64'd1);
`ifdef FRAME_STORE_BOUNDS_CHECK_EN
    checkOutput("c3_err", 64'(err), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("c3_err_cleared", 64'(err), 64'd0);
    startFrame(8'd10, 8'd8, 3'd0);
`else
    checkOutput("c3_err", 64'(err), 64'd0);
`endif

    // 6: luma block one MB row below the picture
    $display("[TB] test 6: out-of-range block");
    base = q_addr.size();
    applyStimulus(2'd0, 8'd0, 8'd9, 2'd0, 2'd0, mkData(6), acc);
    blk_valid = 1'b0;
    repeat (8) @(negedge clk);
`ifdef FRAME_STORE_BOUNDS_CHECK_EN
    checkOutput("t6_count", 64'(q_addr.size() - base), 64'd0);
    checkOutput("t6_err", 64'(err), 64'd1);
    repeat (5) @(negedge clk);
    checkOutput("t6_err_sticky", 64'(err), 64'd1);
    checkOutput("t6_ready", 64'(blk_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_err_reset", 64'(err), 64'd0);
`else
    checkOutput("t6_count", 64'(q_addr.size() - base), 64'd4);
    checkWrites("t6", base, 26'd25344, 26'd176, mkData(6));
    checkOutput("t6_err", 64'(err), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_store_writer.md
Name: frame_store_writer

Overview:
- Write-side feeder of the external frame-store RAM in the H.264 decoder.
- Accepts reconstructed 4x4 pixel blocks (Y, U or V) from the reconstruction stage.
- Computes each block's planar YUV 4:2:0 byte address inside the current picture slot, and emits four 32-bit row writes per block on the RAM write port.
- Signals idle so the frame dumper only starts once every write has landed.

Parameters:
- FIFO_DEPTH_LOG2, 2, log2 of the number of buffered blocks (default 4 entries).
- ADDR_W, 26, width of the RAM byte address.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- start_of_frame  in  1  one-cycle pulse; latches the geometry and pic_num.
- pic_num  in  3  picture slot index for the frame being decoded.
- pic_width_in_mbs_minus1  in  8  picture width in MBs, minus 1.
- pic_height_in_map_units_minus1  in  8  picture height in MBs, minus 1.
- blk_valid  in  1  block offer.
- blk_ready  out  1  block accept.
- blk_comp  in  2  component: 0=Y, 1=U, 2=V; 3 is illegal and the block is dropped.
- mb_x  in  8  MB column.
- mb_y  in  8  MB row.
- blk_x  in  2  4x4 column inside the MB (Y: 0..3, U/V: 0..1).
- blk_y  in  2  4x4 row inside the MB (Y: 0..3, U/V: 0..1).
- blk_data  in  128  16 pixels, row-major; pixel(r,c) is at bits [(r*4+c)*8+7 -: 8].
- ext_wr  out  1  RAM write strobe.
- ext_wr_addr  out  ADDR_W  byte address; always 4-aligned.
- ext_wr_data  out  32  one 4-pixel row; leftmost pixel in [7:0].
- write_to_ram_idle  out  1  high when no block is buffered or being written.
- err  out  1  sticky bounds error (see Optional Feature).

Behaviour:
- Geometry, latched at start_of_frame:
  - W = (pwm1+1)*16, H = (phm1+1)*16.
  - FS = W*H*3/2.
  - fbase = FS*pic_num, truncated to ADDR_W.
  - ubase = fbase + W*H; vbase = ubase + W*H/4.
  - All values are registered one cycle after the pulse.
  - Until the first start_of_frame after reset, the geometry registers are 0.
- Accept: a handshake occurs when blk_valid && blk_ready. blk_ready = !fifo_full.
- Address stage (1 cycle after accept); pushes {row0 address, component pitch, blk_data} into the FIFO.
  - Y: row0 = fbase + (mb_y*16 + blk_y*4)*W + mb_x*16 + blk_x*4; pitch = W.
  - U/V: row0 = (ubase or vbase) + (mb_y*8 + blk_y*4)*(W/2) + mb_x*8 + blk_x*4; pitch = W/2.
  - Arithmetic is unsigned, ADDR_W-wide, wrapping.
  - Because addresses are computed at accept time, a start_of_frame while older blocks are still queued does not alter their addresses.
- Write stage (FSM):
  - IDLE: if the FIFO is non-empty, pop an entry and go to ROW0.
  - ROW0..ROW3: each state drives one write with ext_wr=1, ext_wr_addr = row0 + r*pitch, ext_wr_data = blk_data row r.
  - After ROW3: pop the next entry and go to ROW0 if one is present, else go to IDLE.
  - Back-to-back blocks therefore produce continuous writes with no bubble.
- Latency: a block accepted in cycle N into an empty pipeline writes row0 in cycle N+2 and row3 in cycle N+5. Throughput is one block per 4 cycles.
- Push and pop in the same cycle are legal at any occupancy, including full.
- write_to_ram_idle = FIFO empty && address stage empty && FSM in IDLE.
- Reset values:
  - ext_wr=0, ext_wr_addr=0, ext_wr_data=0.
  - blk_ready=1, write_to_ram_idle=1, err=0.
  - FIFO empty, FSM in IDLE, geometry registers 0.
- Reset mid-operation: queued and in-flight blocks are discarded. ext_wr is 0 in the cycle after rst is sampled high.
- ext_wr_addr and ext_wr_data hold their last values while ext_wr=0.

Optional Feature:
- Macro: FRAME_STORE_BOUNDS_CHECK_EN.
- Enabled: a block is flagged at the address stage if any of the following hold: mb_x > pwm1, mb_y > phm1, a chroma blk_x/blk_y > 1, or blk_comp == 3. A flagged block is never written, err is set and stays set until rst, and blk_ready is unaffected.
- Disabled: no check is made and err is tied to 0. Out-of-range blocks are written at the computed wrapped address; blk_comp==3 blocks are still dropped.

Test Plan:
1. QCIF (pwm1=10, phm1=8), pic_num=0, Y block mb(0,0) blk(0,0), data bytes 0x00..0x0F -> writes at cycles N+2..N+5, addresses 0, 176, 352, 528, data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
2. QCIF, pic_num=1, U block mb(1,2) blk(1,0) -> row0 address 64780, pitch 88; the same coordinates as a V block -> row0 address 71116.
3. Five Y blocks offered back-to-back with blk_valid held high, depth 4 -> blk_ready drops once, 20 consecutive ext_wr cycles with no gap, write_to_ram_idle rises the cycle after the last write.
4. start_of_frame with pic_num=2 pulsed while two pic_num=1 blocks are queued -> the queued blocks write at base 38016; the next block accepted writes at base 76032.
5. rst asserted after the 2nd row write of a block with another block queued -> ext_wr=0 the next cycle, no further writes, write_to_ram_idle=1, blk_ready=1.
6. With FRAME_STORE_BOUNDS_CHECK_EN, QCIF, Y block mb_y=9 -> no ext_wr pulse and err=1 until reset. Without the macro, the same block writes at row0 address 25344.
